// File: rtl/uart_tx_engine.sv
// UART transmit engine: one-entry holding register feeding a start/data/
// parity/stop frame shifter, with gapless back-to-back frames.
module uart_tx_engine #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_BITS-1:0]  hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic                  tx_q, tx_d;

    logic bit_end;
    logic accept;
    logic load;

    assign bit_end  = (baud_q == BAUD_LAST);
    assign accept   = tx_valid && !hold_full_q;
    assign tx_ready = !hold_full_q;
    assign tx       = tx_q;
    assign tx_busy  = (state_q != IDLE);
    assign tx_done  = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        baud_d      = baud_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        tx_d        = tx_q;
        load        = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
        end

        unique case (state_q)
            IDLE: begin
                load = hold_full_q;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        if (PARITY_MODE != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loading empties holding; a new word can only land once it is empty.
        if (load) begin
            state_d     = START;
            shift_d     = hold_q;
            par_d       = (PARITY_MODE == 1) ? ~^hold_q : ^hold_q;
            hold_full_d = 1'b0;
            baud_d      = '0;
            tx_d        = 1'b0;
        end
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            baud_q      <= '0;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three configurations checked cycle by cycle
// against a frame-position model of the serial line.
module tb_uart_tx_engine;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [8:0] dat [3];
    logic       vld [3];
    logic       rdy [3];
    logic       txl [3];
    logic       bsy [3];
    logic       dn  [3];

    int total = 0;
    int bad   = 0;
    int cycno = 0;

    bit         m_act  [3];
    int         m_pos  [3];
    logic [8:0] m_word [3];
    bit         m_hf   [3];
    logic [8:0] m_hw   [3];

    always #5 clk = ~clk;

    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB),
                     .PARITY_MODE(1), .STOP_BITS(1)) u_a (
        .clk(clk), .reset_n(reset_n), .tx_data(dat[0][7:0]),
        .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx(txl[0]),
        .tx_busy(bsy[0]), .tx_done(dn[0]));

    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB),
                     .PARITY_MODE(2), .STOP_BITS(2)) u_b (
        .clk(clk), .reset_n(reset_n), .tx_data(dat[1][7:0]),
        .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx(txl[1]),
        .tx_busy(bsy[1]), .tx_done(dn[1]));

    uart_tx_engine #(.DATA_BITS(7), .CLKS_PER_BIT(CPB),
                     .PARITY_MODE(0), .STOP_BITS(1)) u_c (
        .clk(clk), .reset_n(reset_n), .tx_data(dat[2][6:0]),
        .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx(txl[2]),
        .tx_busy(bsy[2]), .tx_done(dn[2]));

    function automatic int db(int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int pm(int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 0;
    endfunction

    function automatic int sb(int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int flen(int i);
        return (1 + db(i) + ((pm(i) != 0) ? 1 : 0) + sb(i)) * CPB;
    endfunction

    // Line level at a given cycle offset inside a frame.
    function automatic logic bit_at(int i, logic [8:0] w, int pos);
        int idx;
        int ones;
        idx  = pos / CPB;
        ones = 0;
        for (int b = 0; b < db(i); b++) ones += int'(w[b]);
        if (idx == 0) return 1'b0;
        if (idx <= db(i)) return w[idx-1];
        if (idx == db(i) + 1 && pm(i) != 0)
            return (pm(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cycno);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0;
            m_pos[i] = 0;
            m_hf[i]  = 0;
            m_word[i] = '0;
            m_hw[i]  = '0;
        end
    endtask

    task automatic mstep(input int i);
        bit acc;
        acc = vld[i] && !m_hf[i];
        if (m_act[i]) begin
            m_pos[i]++;
            if (m_pos[i] == flen(i)) m_act[i] = 0;
        end
        if (!m_act[i] && m_hf[i]) begin
            m_act[i]  = 1;
            m_pos[i]  = 0;
            m_word[i] = m_hw[i];
            m_hf[i]   = 0;
        end
        if (acc) begin
            m_hf[i] = 1;
            m_hw[i] = dat[i];
        end
    endtask

    task automatic checkall();
        logic etx;
        for (int i = 0; i < 3; i++) begin
            etx = m_act[i] ? bit_at(i, m_word[i], m_pos[i]) : 1'b1;
            chk($sformatf("tx%0d", i), 32'(txl[i]), 32'(etx));
            chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!m_hf[i]));
            chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_act[i]));
            chk($sformatf("done%0d", i), 32'(dn[i]),
                32'(m_act[i] && m_pos[i] == flen(i) - 1));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        cycno++;
        for (int i = 0; i < 3; i++) mstep(i);
        #1;
        checkall();
    endtask

    task automatic drain();
        int k;
        k = 0;
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        while ((m_act[0] || m_act[1] || m_act[2] ||
                m_hf[0] || m_hf[1] || m_hf[2]) && k < 500) begin
            cyc();
            k++;
        end
        chk("drain_bound", 32'(k < 500), 32'd1);
        cyc();
    endtask

    initial begin
        int idx [3];
        bit acc [3];
        int ndone;
        int dc [3];
        int k;
        logic [8:0] words [3];

        words[0] = 9'h11;
        words[1] = 9'h22;
        words[2] = 9'h33;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            dat[i] = '0;
        end
        mreset();
        repeat (3) @(posedge clk);
        #1;
        checkall();
        @(negedge clk);
        reset_n = 1'b1;

        // Single frames: 0xA5 odd/1stop, 0x00 even/2stop, 0x7F 7-bit no parity
        vld[0] = 1'b1; dat[0] = 9'hA5;
        vld[1] = 1'b1; dat[1] = 9'h00;
        vld[2] = 1'b1; dat[2] = 9'h7F;
        cyc();
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        drain();

        // Back-to-back with valid held high
        for (int i = 0; i < 3; i++) idx[i] = 0;
        ndone = 0;
        for (int i = 0; i < 3; i++) dc[i] = 0;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < 3; i++) begin
                vld[i] = (idx[i] < 3);
                dat[i] = words[(idx[i] < 3) ? idx[i] : 0];
                acc[i] = vld[i] && !m_hf[i];
            end
            cyc();
            for (int i = 0; i < 3; i++) if (acc[i]) idx[i]++;
            if (dn[0]) begin
                if (ndone < 3) dc[ndone] = cycno;
                ndone++;
            end
        end
        chk("a_ndone", 32'(ndone), 32'd3);
        chk("a_gap1", 32'(dc[1] - dc[0]), 32'd44);
        chk("a_gap2", 32'(dc[2] - dc[1]), 32'd44);
        drain();

        // Reset during DATA bit 3 of configuration A
        vld[0] = 1'b1; dat[0] = 9'h5A;
        vld[1] = 1'b1; dat[1] = 9'h3C;
        cyc();
        vld[0] = 1'b0; vld[1] = 1'b0;
        k = 0;
        while (!(m_act[0] && m_pos[0] / CPB == 4) && k < 100) begin
            cyc();
            k++;
        end
        chk("rst_reach_bit3", 32'(k < 100), 32'd1);
        vld[0] = 1'b1; dat[0] = 9'h66;
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx%0d", i), 32'(txl[i]), 32'd1);
            chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
            chk($sformatf("rst_done%0d", i), 32'(dn[i]), 32'd0);
        end
        mreset();
        #2;
        reset_n = 1'b1;
        cyc();
        vld[0] = 1'b0;
        drain();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                vld[i] = ($urandom % 3) == 0;
                dat[i] = 9'($urandom) & 9'((1 << db(i)) - 1);
            end
            cyc();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
